// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment message scroller.
// Glyphs are active-low with bit order {g,f,e,d,c,b,a}.
package seg_pkg;

   typedef enum logic [1:0] {
      MODE_STATIC = 2'd0,
      MODE_SCROLL = 2'd1,
      MODE_BLINK  = 2'd2,
      MODE_REVEAL = 2'd3
   } mode_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic [6:0] GLYPH_0 = 7'h40;
   localparam logic [6:0] GLYPH_1 = 7'h79;
   localparam logic [6:0] GLYPH_2 = 7'h24;
   localparam logic [6:0] GLYPH_3 = 7'h30;
   localparam logic [6:0] GLYPH_4 = 7'h19;
   localparam logic [6:0] GLYPH_5 = 7'h12;
   localparam logic [6:0] GLYPH_6 = 7'h02;
   localparam logic [6:0] GLYPH_7 = 7'h78;
   localparam logic [6:0] GLYPH_8 = 7'h00;
   localparam logic [6:0] GLYPH_9 = 7'h10;
   localparam logic [6:0] GLYPH_A = 7'h08;
   localparam logic [6:0] GLYPH_E = 7'h06;
   localparam logic [6:0] GLYPH_H = 7'h09;
   localparam logic [6:0] GLYPH_L = 7'h47;
   localparam logic [6:0] GLYPH_O = 7'h40;
   localparam logic [6:0] GLYPH_P = 7'h0C;

   // Maps a decimal value to its glyph; anything above 9 renders blank.
   function automatic logic [6:0] digitGlyph(input logic [3:0] value);
      logic [6:0] glyph;
      glyph = SEG_BLANK;
      case (value)
         4'd0: glyph = GLYPH_0;
         4'd1: glyph = GLYPH_1;
         4'd2: glyph = GLYPH_2;
         4'd3: glyph = GLYPH_3;
         4'd4: glyph = GLYPH_4;
         4'd5: glyph = GLYPH_5;
         4'd6: glyph = GLYPH_6;
         4'd7: glyph = GLYPH_7;
         4'd8: glyph = GLYPH_8;
         4'd9: glyph = GLYPH_9;
         default: glyph = SEG_BLANK;
      endcase
      return glyph;
   endfunction

endpackage

// File: rtl/seg_msg_scroller_tick_div.sv
// Free-running divider producing a one-cycle tick every DIV enabled cycles.
// The count freezes while EN is low so a paused display resumes in phase.
module tick_div #(
   parameter int DIV = 4
) (
   input  logic CLOCK,
   input  logic RESET_N,
   input  logic EN,
   output logic tick
);

   localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] r_count;
   logic          w_atLast;

   assign w_atLast = (r_count == LAST);
   assign tick     = EN && w_atLast;

   // Count 0..DIV-1 while enabled, wrapping on the tick cycle.
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_count <= '0;
      end else if (EN) begin
         if (w_atLast) begin
            r_count <= '0;
         end else begin
            r_count <= r_count + 1'b1;
         end
      end
   end

endmodule

// File: rtl/seg_msg_scroller.sv
// Multiplexed seven-segment message display with static, scroll, blink
// and reveal animations driven from a writable glyph buffer.
module seg_msg_scroller
   import seg_pkg::*;
#(
   parameter int N_DIGITS    = 4,
   parameter int MSG_LEN     = 8,
   parameter int REFRESH_DIV = 262144,
   parameter int STEP_DIV    = 100000000
) (
   input  logic                       CLOCK,
   input  logic                       RESET_N,
   input  logic                       EN,
   input  logic [1:0]                 MODE,
   input  logic                       WE,
   input  logic [$clog2(MSG_LEN)-1:0] WADDR,
   input  logic [6:0]                 WDATA,
   output logic [N_DIGITS-1:0]        an,
   output logic [6:0]                 seg
);

   localparam int AW = $clog2(MSG_LEN);
   localparam int DW = $clog2(N_DIGITS);
   localparam int RW = $clog2(N_DIGITS + 1);

   localparam logic [AW:0]   LEN_EXT     = (AW+1)'(MSG_LEN);
   localparam logic [AW-1:0] LAST_OFFSET = AW'(MSG_LEN - 1);
   localparam logic [DW-1:0] LAST_DIGIT  = DW'(N_DIGITS - 1);
   localparam logic [RW-1:0] REVEAL_MAX  = RW'(N_DIGITS);

   logic [6:0]    r_buf [MSG_LEN];
   logic [DW-1:0] r_digit;
   logic [AW-1:0] r_offset;
   logic          r_phase;
   logic [RW-1:0] r_reveal;
   mode_t         r_modePrev;

   logic          w_refreshTick;
   logic          w_stepTick;
   mode_t         w_mode;
   logic          w_modeChange;
   logic          w_waddrOk;
   logic [AW-1:0] w_offsetNext;
   logic          w_phaseNext;
   logic [RW-1:0] w_revealNext;
   logic [AW:0]   w_scrollSum;
   logic [AW:0]   w_scrollWrap;
   logic [AW-1:0] w_scrollIdx;
   logic [6:0]    w_glyph;
   logic [N_DIGITS-1:0] w_anSel;

   tick_div #(.DIV(REFRESH_DIV)) u_refreshDiv (
      .CLOCK   (CLOCK),
      .RESET_N (RESET_N),
      .EN      (EN),
      .tick    (w_refreshTick)
   );

   tick_div #(.DIV(STEP_DIV)) u_stepDiv (
      .CLOCK   (CLOCK),
      .RESET_N (RESET_N),
      .EN      (EN),
      .tick    (w_stepTick)
   );

   assign w_mode       = mode_t'(MODE);
   assign w_modeChange = EN && (w_mode != r_modePrev);
   assign w_waddrOk    = ({1'b0, WADDR} < LEN_EXT);

   // Animation state for the coming cycle; a mode change restarts the
   // animation and takes priority over a coincident step tick.
   always_comb begin
      w_offsetNext = r_offset;
      w_phaseNext  = r_phase;
      w_revealNext = r_reveal;
      if (w_modeChange) begin
         w_offsetNext = '0;
         w_phaseNext  = 1'b0;
         w_revealNext = '0;
      end else if (w_stepTick) begin
         w_offsetNext = (r_offset == LAST_OFFSET) ? '0 : r_offset + 1'b1;
         w_phaseNext  = ~r_phase;
         if (r_reveal != REVEAL_MAX) begin
            w_revealNext = r_reveal + 1'b1;
         end
      end
   end

   assign w_scrollSum  = {1'b0, w_offsetNext} + (AW+1)'(r_digit);
   assign w_scrollWrap = (w_scrollSum >= LEN_EXT) ? (w_scrollSum - LEN_EXT) : w_scrollSum;
   assign w_scrollIdx  = w_scrollWrap[AW-1:0];
   assign w_anSel      = ~({{(N_DIGITS-1){1'b0}}, 1'b1} << (LAST_DIGIT - r_digit));

   // Glyph for the digit being drawn, using the post-step animation state
   // so a step landing on a refresh is visible immediately.
   always_comb begin
      w_glyph = SEG_BLANK;
      case (w_mode)
         MODE_STATIC: w_glyph = r_buf[r_digit];
         MODE_SCROLL: w_glyph = r_buf[w_scrollIdx];
         MODE_BLINK:  w_glyph = w_phaseNext ? SEG_BLANK : r_buf[r_digit];
         MODE_REVEAL: w_glyph = (RW'(r_digit) < w_revealNext) ? r_buf[r_digit] : SEG_BLANK;
         default:     w_glyph = SEG_BLANK;
      endcase
   end

   // Message buffer; out-of-range addresses are dropped.
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         for (int i = 0; i < MSG_LEN; i++) begin
            r_buf[i] <= SEG_BLANK;
         end
      end else if (WE && w_waddrOk) begin
         r_buf[WADDR] <= WDATA;
      end
   end

   // Scan, animation and registered outputs; disabling blanks the display
   // and freezes every counter where it stands.
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_digit    <= '0;
         r_offset   <= '0;
         r_phase    <= 1'b0;
         r_reveal   <= '0;
         r_modePrev <= MODE_STATIC;
         an         <= '1;
         seg        <= SEG_BLANK;
      end else if (EN) begin
         r_modePrev <= w_mode;
         r_offset   <= w_offsetNext;
         r_phase    <= w_phaseNext;
         r_reveal   <= w_revealNext;
         if (w_refreshTick) begin
            r_digit <= (r_digit == LAST_DIGIT) ? '0 : r_digit + 1'b1;
            an      <= w_anSel;
            seg     <= w_glyph;
         end
      end else begin
         an  <= '1;
         seg <= SEG_BLANK;
      end
   end

endmodule
